// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and types for the PS/2 receive path
//
// Purpose: prefix byte values, frame bit positions, receiver FSM state
// encoding and the FIFO entry layout used by ps2_rx_fifo.
// Ports: none (package).

package ps2_pkg;

  localparam logic [7:0] PS2_EXT_PREFIX = 8'hE0;
  localparam logic [7:0] PS2_BRK_PREFIX = 8'hF0;

  // Positions inside the 10-bit post-start frame (data bits are 0..7).
  localparam int PARITY_BIT = 8;
  localparam int STOP_BIT   = 9;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } ps2_state_e;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;

  // PS/2 uses odd parity over the eight data bits plus the parity bit.
  function automatic logic odd_parity_ok(input logic [8:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - 2-FF synchroniser plus run-length glitch filter
//
// Purpose: brings one asynchronous PS/2 line into the clk domain and only
// lets the filtered level change once FILTER_LEN consecutive synchronised
// samples agree on the new value.
// Ports:
//   clk    in   system clock
//   rst_n  in   asynchronous active-low reset (filtered level resets to 1)
//   din    in   raw asynchronous line
//   level  out  filtered line level
//   fall   out  one-cycle strobe on a filtered 1->0 transition

module ps2_line_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic fall
);

  localparam int CW = $clog2(FILTER_LEN) + 1;

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] run_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      level   <= 1'b1;
      fall    <= 1'b0;
      run_cnt <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      fall  <= 1'b0;
      if (sync2 == level) begin
        // Any sample matching the current level restarts the run.
        run_cnt <= '0;
      end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
        level   <= sync2;
        run_cnt <= '0;
        fall    <= level & ~sync2;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// rtl/ps2_rx_fifo.sv - PS/2 device-to-host receiver with show-ahead code FIFO
//
// Purpose: filters PS2CLK/PS2DAT, deframes 11-bit PS/2 frames, checks start,
// parity and stop bits, folds E0/F0 prefixes into ext/brk flags and buffers
// the resulting codes in a show-ahead FIFO.
// Ports:
//   CLK         in   system clock
//   reset       in   asynchronous active-low reset
//   PS2CLK      in   raw PS/2 clock pin
//   PS2DAT      in   raw PS/2 data pin
//   rd_en       in   pop head entry (ignored when empty)
//   clr_err     in   clear overflow sticky bit
//   rd_valid    out  FIFO non-empty
//   rd_code     out  head scan code
//   rd_brk      out  head entry was preceded by F0
//   rd_ext      out  head entry was preceded by E0
//   fifo_count  out  number of entries held
//   overflow    out  sticky: an entry was dropped on a full FIFO
//   err_parity  out  one-cycle pulse: parity failure
//   err_frame   out  one-cycle pulse: bad stop bit or frame timeout

module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int CNT_W          = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             PS2CLK,
  input  logic             PS2DAT,
  input  logic             rd_en,
  input  logic             clr_err,
  output logic             rd_valid,
  output logic [7:0]       rd_code,
  output logic             rd_brk,
  output logic             rd_ext,
  output logic [CNT_W-1:0] fifo_count,
  output logic             overflow,
  output logic             err_parity,
  output logic             err_frame
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  // ---------------------------------------------------------------- inputs
  logic clk_level;
  logic clk_fall;
  logic dat_level;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (CLK),
    .rst_n (reset),
    .din   (PS2CLK),
    .level (clk_level),
    .fall  (clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk   (CLK),
    .rst_n (reset),
    .din   (PS2DAT),
    .level (dat_level),
    .fall  ()
  );

  // ------------------------------------------------------------------- FSM
  ps2_state_e      state, state_d;
  logic [3:0]      bit_cnt, bit_cnt_d;
  logic [9:0]      frame_sr, frame_sr_d;
  logic [TO_W-1:0] to_cnt, to_cnt_d;
  logic            ext_pend, ext_pend_d;
  logic            brk_pend, brk_pend_d;
  logic            push;
  ps2_entry_t      push_entry;

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      frame_sr <= '0;
      to_cnt   <= '0;
      ext_pend <= 1'b0;
      brk_pend <= 1'b0;
    end else begin
      state    <= state_d;
      bit_cnt  <= bit_cnt_d;
      frame_sr <= frame_sr_d;
      to_cnt   <= to_cnt_d;
      ext_pend <= ext_pend_d;
      brk_pend <= brk_pend_d;
    end
  end

  always_comb begin
    state_d    = state;
    bit_cnt_d  = bit_cnt;
    frame_sr_d = frame_sr;
    to_cnt_d   = to_cnt;
    ext_pend_d = ext_pend;
    brk_pend_d = brk_pend;
    push       = 1'b0;
    push_entry = '{ext: ext_pend, brk: brk_pend, code: frame_sr[7:0]};
    err_parity = 1'b0;
    err_frame  = 1'b0;

    unique case (state)
      IDLE: begin
        // A falling edge with DAT high is not a start bit; ignore it quietly.
        if (clk_fall && !dat_level) begin
          state_d   = RECV;
          bit_cnt_d = '0;
          to_cnt_d  = '0;
        end
      end

      RECV: begin
        if (clk_fall) begin
          // LSB first: after ten shifts the stop bit sits in bit 9.
          frame_sr_d = {dat_level, frame_sr[9:1]};
          to_cnt_d   = '0;
          if (bit_cnt == 4'(STOP_BIT)) begin
            state_d = DONE;
          end else begin
            bit_cnt_d = bit_cnt + 4'd1;
          end
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_frame  = 1'b1;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
          state_d    = IDLE;
        end else begin
          to_cnt_d = to_cnt + 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        if (!frame_sr[STOP_BIT]) begin
          err_frame  = 1'b1;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end else if (!odd_parity_ok(frame_sr[PARITY_BIT:0])) begin
          err_parity = 1'b1;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end else if (frame_sr[7:0] == PS2_EXT_PREFIX) begin
          ext_pend_d = 1'b1;
        end else if (frame_sr[7:0] == PS2_BRK_PREFIX) begin
          brk_pend_d = 1'b1;
        end else begin
          push       = 1'b1;
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // ------------------------------------------------------------------ FIFO
  ps2_entry_t mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          fifo_full;
  logic          do_pop;
  logic          do_push;
  logic          ovf_set;
  ps2_entry_t    head;

  assign rd_valid  = (fifo_count != '0);
  assign fifo_full = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign do_pop    = rd_en && rd_valid;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push   = push && (!fifo_full || do_pop);
  assign ovf_set   = push && fifo_full && !do_pop;

  assign head    = mem[rd_ptr];
  // Storage is not reset, so gate the head so outputs read 0 when empty.
  assign rd_code = rd_valid ? head.code : 8'h00;
  assign rd_brk  = rd_valid & head.brk;
  assign rd_ext  = rd_valid & head.ext;

  always_ff @(posedge CLK) begin
    if (do_push) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      // A new overflow wins over a simultaneous clear.
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// tb/tb_ps2_rx_fifo.sv - self-checking bench for ps2_rx_fifo

module tb_ps2_rx_fifo;

  localparam int DEPTH = 4;
  localparam int FL    = 4;
  localparam int TMO   = 200;
  localparam int HALF  = 12;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          reset = 1'b0;
  logic          PS2CLK = 1'b1;
  logic          PS2DAT = 1'b1;
  logic          rd_en = 1'b0;
  logic          clr_err = 1'b0;
  logic          rd_valid;
  logic [7:0]    rd_code;
  logic          rd_brk;
  logic          rd_ext;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          err_parity;
  logic          err_frame;

  always #5 CLK = ~CLK;

  ps2_rx_fifo #(
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (FL),
    .TIMEOUT_CYCLES (TMO),
    .CNT_W          (CW)
  ) dut (
    .CLK        (CLK),
    .reset      (reset),
    .PS2CLK     (PS2CLK),
    .PS2DAT     (PS2DAT),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .rd_valid   (rd_valid),
    .rd_code    (rd_code),
    .rd_brk     (rd_brk),
    .rd_ext     (rd_ext),
    .fifo_count (fifo_count),
    .overflow   (overflow),
    .err_parity (err_parity),
    .err_frame  (err_frame)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: queue of {ext,brk,code}, pending prefix flags, sticky overflow.
  logic [9:0] mq[$];
  bit m_ext = 0;
  bit m_brk = 0;
  bit m_ovf = 0;
  int exp_par = 0;
  int exp_frm = 0;
  int seen_par = 0;
  int seen_frm = 0;

  always @(negedge CLK) begin
    if (err_parity) seen_par++;
    if (err_frame)  seen_frm++;
  end

  task automatic model_frame(input logic [7:0] d, input bit pg, input bit sg, input bit pop_same);
    if (pop_same && mq.size() > 0) void'(mq.pop_front());
    if (!sg) begin
      exp_frm++; m_ext = 0; m_brk = 0;
    end else if (!pg) begin
      exp_par++; m_ext = 0; m_brk = 0;
    end else if (d == 8'hE0) begin
      m_ext = 1;
    end else if (d == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (mq.size() < DEPTH) mq.push_back({m_ext, m_brk, d});
      else m_ovf = 1;
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit pg, input bit sg,
                            input int glitch, input bit pop_same, output int lat);
    logic [10:0] bits;
    logic        p;
    bit          pre;
    p    = pg ? ~^d : ^d;
    bits = {sg, p, d, 1'b0};
    lat  = 0;
    pre  = rd_valid;
    for (int i = 0; i < 11; i++) begin
      PS2DAT = bits[i];
      repeat (HALF) @(negedge CLK);
      PS2CLK = 1'b0;
      if (i == 10) begin
        for (int j = 1; j <= HALF; j++) begin
          @(negedge CLK);
          if (pop_same && j == FL + 3) rd_en = 1'b1;
          if (j == FL + 4) rd_en = 1'b0;
          if (lat == 0 && !pre && rd_valid) lat = j;
        end
      end else begin
        repeat (HALF) @(negedge CLK);
      end
      PS2CLK = 1'b1;
      if (glitch > 0 && i == 4) begin
        repeat (3) @(negedge CLK);
        PS2CLK = 1'b0;
        repeat (glitch) @(negedge CLK);
        PS2CLK = 1'b1;
      end
    end
    PS2DAT = 1'b1;
    repeat (HALF) @(negedge CLK);
  endtask

  task automatic send_partial(input int n);
    PS2DAT = 1'b0;
    for (int i = 0; i <= n; i++) begin
      repeat (HALF) @(negedge CLK);
      PS2CLK = 1'b0;
      repeat (HALF) @(negedge CLK);
      PS2CLK = 1'b1;
      PS2DAT = 1'b1;
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".count"}, fifo_count, mq.size());
    check({tag, ".valid"}, rd_valid, mq.size() != 0);
    check({tag, ".ovf"}, overflow, m_ovf);
    check({tag, ".perr"}, seen_par, exp_par);
    check({tag, ".ferr"}, seen_frm, exp_frm);
    if (mq.size() != 0) check({tag, ".head"}, {rd_ext, rd_brk, rd_code}, mq[0]);
  endtask

  task automatic do_frame(input string tag, input logic [7:0] d, input bit pg, input bit sg,
                          input int glitch, input bit pop_same);
    int lat;
    send_frame(d, pg, sg, glitch, pop_same, lat);
    model_frame(d, pg, sg, pop_same);
    check_state(tag);
  endtask

  task automatic pop_one(input string tag);
    if (mq.size() != 0) check({tag, ".pophead"}, {rd_ext, rd_brk, rd_code}, mq[0]);
    rd_en = 1'b1;
    @(negedge CLK);
    rd_en = 1'b0;
    if (mq.size() != 0) void'(mq.pop_front());
    check({tag, ".popcnt"}, fifo_count, mq.size());
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < DEPTH + 2 && mq.size() != 0; k++) pop_one(tag);
  endtask

  initial begin
    int lat;
    logic [7:0] d;
    bit pg, sg, ps;

    repeat (3) @(negedge CLK);
    check("rst.valid", rd_valid, 0);
    check("rst.count", fifo_count, 0);
    check("rst.ovf", overflow, 0);
    check("rst.out", {rd_ext, rd_brk, rd_code, err_parity, err_frame}, 0);
    reset = 1'b1;
    repeat (5) @(negedge CLK);

    // Clean frame and receive latency
    send_frame(8'h15, 1, 1, 0, 0, lat);
    model_frame(8'h15, 1, 1, 0);
    check("t1.latency", lat, FL + 4);
    check_state("t1");
    pop_one("t1");

    // Prefix folding
    do_frame("t2a", 8'hF0, 1, 1, 0, 0);
    do_frame("t2b", 8'h1C, 1, 1, 0, 0);
    check("t2.brk", {rd_ext, rd_brk, rd_code}, {2'b01, 8'h1C});
    pop_one("t2b");
    do_frame("t2c", 8'hE0, 1, 1, 0, 0);
    do_frame("t2d", 8'hF0, 1, 1, 0, 0);
    do_frame("t2e", 8'h75, 1, 1, 0, 0);
    check("t2.extbrk", {rd_ext, rd_brk, rd_code}, {2'b11, 8'h75});
    pop_one("t2e");

    // Parity and stop errors
    do_frame("t3a", 8'h1C, 0, 1, 0, 0);
    do_frame("t3b", 8'hF0, 1, 1, 0, 0);
    do_frame("t3c", 8'h33, 1, 0, 0, 0);
    do_frame("t3d", 8'h1C, 1, 1, 0, 0);
    check("t3.nobrk", {rd_ext, rd_brk, rd_code}, {2'b00, 8'h1C});
    pop_one("t3d");

    // Timeout recovery
    do_frame("t4a", 8'hF0, 1, 1, 0, 0);
    send_partial(4);
    repeat (TMO + 50) @(negedge CLK);
    exp_frm++; m_ext = 0; m_brk = 0;
    check_state("t4b");
    do_frame("t4c", 8'h15, 1, 1, 0, 0);
    check("t4.code", {rd_ext, rd_brk, rd_code}, {2'b00, 8'h15});
    pop_one("t4c");

    // Overflow, clear, full with coincident pop
    for (int i = 0; i <= DEPTH; i++) do_frame("t5fill", 8'h10 + 8'(i), 1, 1, 0, 0);
    check("t5.full", fifo_count, DEPTH);
    check("t5.ovf", overflow, 1);
    for (int i = 0; i < DEPTH; i++) begin
      check("t5.order", rd_code, 8'h10 + 8'(i));
      pop_one("t5rd");
    end
    pop_one("t5empty");
    clr_err = 1'b1;
    @(negedge CLK);
    clr_err = 1'b0;
    m_ovf = 0;
    check("t5.clr", overflow, 0);
    for (int i = 0; i < DEPTH; i++) do_frame("t5fill2", 8'h20 + 8'(i), 1, 1, 0, 0);
    do_frame("t5same", 8'h2F, 1, 1, 0, 1);
    check("t5.same.ovf", overflow, 0);
    check("t5.same.cnt", fifo_count, DEPTH);
    drain("t5drain");

    // Glitches and mid-frame reset
    do_frame("t6g1", 8'h2A, 1, 1, 1, 0);
    do_frame("t6g2", 8'h3B, 1, 1, FL - 1, 0);
    drain("t6drain");
    do_frame("t6pre", 8'h44, 1, 1, 0, 0);
    send_partial(5);
    reset = 1'b0;
    #1;
    check("t6.rst.valid", rd_valid, 0);
    check("t6.rst.count", fifo_count, 0);
    check("t6.rst.code", rd_code, 0);
    mq.delete(); m_ext = 0; m_brk = 0; m_ovf = 0;
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    repeat (5) @(negedge CLK);
    do_frame("t6post", 8'h1C, 1, 1, 0, 0);
    check("t6.post", {rd_ext, rd_brk, rd_code}, {2'b00, 8'h1C});
    pop_one("t6post");

    // Randomized frames against the model
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 9))
        0: d = 8'hE0;
        1: d = 8'hF0;
        default: d = 8'($urandom_range(0, 255));
      endcase
      pg = ($urandom_range(0, 7) != 0);
      sg = ($urandom_range(0, 9) != 0);
      ps = ($urandom_range(0, 5) == 0);
      do_frame("rnd", d, pg, sg, 0, ps);
      if ($urandom_range(0, 2) == 0) pop_one("rndpop");
      if (m_ovf && $urandom_range(0, 3) == 0) begin
        clr_err = 1'b1;
        @(negedge CLK);
        clr_err = 1'b0;
        m_ovf = 0;
        check("rnd.clr", overflow, 0);
      end
    end
    drain("rnddrain");
    check_state("final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
